mux2x5_arbiter: RTL and testbench
=================================

Name: mux2x5_arbiter

Overview:
- Shares one 5-bit 2-to-1 selection datapath between two requesters (port 0, port 1).
- Grants the datapath in bounded bursts with round-robin fairness.
- Drives the mux select and registers the selected word into a valid/ready output stage.
- Sits upstream of any single-consumer 5-bit sink, such as a register-address or write-port path.

Parameters:
- WIDTH, 5, data width of a0/a1/y. Fixed at 5 for this block; parameterised for reuse only.
- BURST_LEN, 4, maximum consecutive accepted transfers from one owner while the other port is requesting. Legal range 1..15.
- CNT_W, 4, width of the burst counter. Must satisfy 2^CNT_W > BURST_LEN.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- req0  input  1  port 0 has a word to send.
- a0  input  WIDTH  port 0 data.
- gnt0  output  1  port 0 transfer accepted this cycle when req0 && gnt0.
- req1  input  1  port 1 has a word to send.
- a1  input  WIDTH  port 1 data.
- gnt1  output  1  port 1 transfer accepted this cycle when req1 && gnt1.
- selection  output  1  mux select. 0 = a0, 1 = a1. Equals current owner.
- y  output  WIDTH  registered output word.
- y_valid  output  1  y holds an unconsumed word.
- y_ready  input  1  downstream accepts y this cycle when y_valid && y_ready.
- busy  output  1  state != IDLE.

Behaviour:
- Clock and reset: one clock, clk. Reset is asynchronous, active-high, port name reset.
- Reset values:
  - state = IDLE, burst count = 0, last_owner = 1 (port 0 wins the first tie).
  - selection = 0, y = 0, y_valid = 0, gnt0 = gnt1 = 0, busy = 0.
- States:
  - IDLE: no grant.
  - OWN0: selection = 0.
  - OWN1: selection = 1.
- Output stage free: stage_free = !y_valid || y_ready.
- Grants (combinational from registered state):
  - gnt0 = (state == OWN0) && stage_free.
  - gnt1 = (state == OWN1) && stage_free.
  - A grant is never asserted in IDLE.
- Accept: acc = reqN && gntN for the owner N. On acc: y <= aN (via the mux at selection), y_valid <= 1.
- Drain: if y_valid && y_ready && !acc, then y_valid <= 0.
- Hold: while y_valid && !y_ready, y and y_valid hold stable.
- IDLE transitions:
  - Only req0: go to OWN0.
  - Only req1: go to OWN1.
  - Both: go to OWN(!last_owner).
  - Neither: stay in IDLE.
  - Count cleared in every case.
- OWNn transitions, evaluated each cycle, first match wins:
  1. !reqN and other req: go to OWN(other), count = 0, last_owner = N.
  2. !reqN and no other req: go to IDLE, last_owner = N.
  3. acc and count == BURST_LEN-1 and other req: go to OWN(other), count = 0, last_owner = N.
  4. acc: count++, saturating at BURST_LEN-1. Stay in OWNn.
  5. Otherwise: stay in OWNn; count unchanged.
- No other requester: the owner keeps the datapath indefinitely. The counter saturates and does not force a switch.
- Latency:
  - Request arriving in IDLE at cycle t: grant at t+1, y_valid at t+2 (with y_ready high).
  - Owner switch costs zero idle cycles. The new owner's grant is visible the cycle after the switch decision.
- Throughput: one word per cycle while y_ready stays high.
- Requester contract: requesters hold aN stable and reqN high until accepted. The arbiter does not check this.
- Reset mid-operation: all state returns to reset values immediately (asynchronous). Any in-flight y word is discarded.

Decomposition:
- Shared header (`include`):
  - State encodings: IDLE = 2'd0, OWN0 = 2'd1, OWN1 = 2'd2.
  - Default BURST_LEN.
- Sub-module: instantiate the existing mux2x5 for the data select, with selection driving its select input.
- FSM, counter and output register live in mux2x5_arbiter.

Test Plan:
- Reset check: assert reset mid-burst with y_valid = 1 -> next sample shows y = 0, y_valid = 0, gnt0 = gnt1 = 0, busy = 0, selection = 0.
- Single requester: req0 = 1, a0 = 5'h0A/0B/0C/0D/0E on successive accepts, y_ready = 1 -> gnt0 at t+1, y sequence 0A..0E from t+2, no gaps, selection = 0 throughout.
- Tie and fairness, BURST_LEN = 4: req0 = req1 = 1 from reset, y_ready = 1 -> four words from port 0, then four from port 1, alternating. First grant goes to port 0.
- Backpressure: y_ready = 0 for 3 cycles after the first word -> y and y_valid hold; gnt0 = 0; no accepts and no counter advance; resumes when y_ready = 1.
- Owner drop with waiting peer: in OWN0, deassert req0 while req1 = 1 -> OWN1 next cycle, gnt1 the cycle after, zero cycles spent in IDLE.
- BURST_LEN = 1: both requesting -> strict alternation 0, 1, 0, 1 of selection per accepted word.

Source files
------------

// File: rtl/mux2x5_arbiter_pkg.sv
// Shared types and defaults for the two-port burst arbiter in front of mux2x5.
// State encodings are fixed so that they stay stable across every user of the block.
package mux2x5_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   localparam int DEFAULT_WIDTH     = 5;
   localparam int DEFAULT_BURST_LEN = 4;
   localparam int DEFAULT_CNT_W     = 4;

   function automatic state_t own_state(input logic port);
      return port ? OWN1 : OWN0;
   endfunction

endpackage

// File: rtl/mux2x5_arbiter_if.sv
// Request/grant and valid/ready bundle around the arbiter.
// master = requesters plus downstream sink; slave = the arbiter itself.
interface mux2x5_arbiter_if #(
   parameter int WIDTH = 5
);
   logic             req0;
   logic [WIDTH-1:0] a0;
   logic             gnt0;
   logic             req1;
   logic [WIDTH-1:0] a1;
   logic             gnt1;
   logic             selection;
   logic [WIDTH-1:0] y;
   logic             y_valid;
   logic             y_ready;
   logic             busy;

   modport master (
      output req0, a0, req1, a1, y_ready,
      input  gnt0, gnt1, selection, y, y_valid, busy
   );

   modport slave (
      input  req0, a0, req1, a1, y_ready,
      output gnt0, gnt1, selection, y, y_valid, busy
   );
endinterface

// File: rtl/mux2x5_arbiter_mux.sv
// Plain 2-to-1 word select shared by both arbiter ports.
module mux2x5 #(
   parameter int WIDTH = 5
) (
   input  logic [WIDTH-1:0] a0,
   input  logic [WIDTH-1:0] a1,
   input  logic             sel,
   output logic [WIDTH-1:0] y
);
   assign y = sel ? a1 : a0;
endmodule

// File: rtl/mux2x5_arbiter.sv
// Round-robin burst arbiter: owns the mux select and registers the chosen word
// into a single valid/ready output stage.
module mux2x5_arbiter
   import mux2x5_arbiter_pkg::*;
#(
   parameter int WIDTH     = DEFAULT_WIDTH,
   parameter int BURST_LEN = DEFAULT_BURST_LEN,
   parameter int CNT_W     = DEFAULT_CNT_W
) (
   input logic             clk,
   input logic             reset,
   mux2x5_arbiter_if.slave bus
);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_LEN - 1);

   state_t           state, state_nxt;
   logic [CNT_W-1:0] count, count_nxt;
   logic             last_owner, last_owner_nxt;
   logic [WIDTH-1:0] y_q, mux_y;
   logic             y_valid_q;
   logic             stage_free, owner, own_req, other_req;
   logic             gnt0, gnt1, acc;

   // Grants come only from registered state, so the requesters never see a
   // combinational path from their own req back to their grant.
   assign stage_free = !y_valid_q || bus.y_ready;
   assign owner      = (state == OWN1);
   assign own_req    = owner ? bus.req1 : bus.req0;
   assign other_req  = owner ? bus.req0 : bus.req1;
   assign gnt0       = (state == OWN0) && stage_free;
   assign gnt1       = (state == OWN1) && stage_free;
   assign acc        = (gnt0 && bus.req0) || (gnt1 && bus.req1);

   assign bus.gnt0      = gnt0;
   assign bus.gnt1      = gnt1;
   assign bus.selection = owner;
   assign bus.busy      = (state != IDLE);
   assign bus.y         = y_q;
   assign bus.y_valid   = y_valid_q;

   mux2x5 #(.WIDTH(WIDTH)) u_mux (
      .a0  (bus.a0),
      .a1  (bus.a1),
      .sel (owner),
      .y   (mux_y)
   );

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of block ordering.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         count      <= '0;
         last_owner <= 1'b1;
      end else begin
         state      <= state_nxt;
         count      <= count_nxt;
         last_owner <= last_owner_nxt;
      end
   end

   // NOTE: every output of this block gets a default first, so no path can
   // leave a value unassigned and infer a latch.
   always_comb begin
      state_nxt      = state;
      count_nxt      = count;
      last_owner_nxt = last_owner;
      unique case (state)
         IDLE: begin
            count_nxt = '0;
            if (bus.req0 && bus.req1) state_nxt = own_state(!last_owner);
            else if (bus.req0)        state_nxt = OWN0;
            else if (bus.req1)        state_nxt = OWN1;
         end
         OWN0, OWN1: begin
            if (!own_req && other_req) begin
               state_nxt      = own_state(!owner);
               count_nxt      = '0;
               last_owner_nxt = owner;
            end else if (!own_req) begin
               state_nxt      = IDLE;
               last_owner_nxt = owner;
            end else if (acc && count == CNT_LAST && other_req) begin
               state_nxt      = own_state(!owner);
               count_nxt      = '0;
               last_owner_nxt = owner;
            end else if (acc && count != CNT_LAST) begin
               count_nxt = count + CNT_W'(1);
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // An accept always wins over a drain: the stage is refilled in the same cycle.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         y_q       <= '0;
         y_valid_q <= 1'b0;
      end else if (acc) begin
         y_q       <= mux_y;
         y_valid_q <= 1'b1;
      end else if (y_valid_q && bus.y_ready) begin
         y_valid_q <= 1'b0;
      end
   end

endmodule

// File: tb/tb_mux2x5_arbiter.sv
// Scoreboard bench for mux2x5_arbiter: BURST_LEN=4 and BURST_LEN=1 instances,
// directed requester traffic, per-instance output monitors.
module tb_mux2x5_arbiter;

   logic clk;
   logic reset;

   mux2x5_arbiter_if #(.WIDTH(5)) if4 ();
   mux2x5_arbiter_if #(.WIDTH(5)) if1 ();

   mux2x5_arbiter #(.WIDTH(5), .BURST_LEN(4), .CNT_W(4)) dut4 (
      .clk   (clk),
      .reset (reset),
      .bus   (if4)
   );

   mux2x5_arbiter #(.WIDTH(5), .BURST_LEN(1), .CNT_W(4)) dut1 (
      .clk   (clk),
      .reset (reset),
      .bus   (if1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Requester models, index: 0 = dut4 port0, 1 = dut4 port1, 2 = dut1 port0, 3 = dut1 port1.
   // Word = {port, idx}; idx advances only when that word is accepted.
   int         left [4];
   logic [3:0] idx  [4];

   logic [4:0] q4 [$];
   logic [4:0] q1 [$];

   logic alt_en  = 1'b0;
   logic alt_sel = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic drive();
      if4.req0 = (left[0] > 0); if4.a0 = {1'b0, idx[0]};
      if4.req1 = (left[1] > 0); if4.a1 = {1'b1, idx[1]};
      if1.req0 = (left[2] > 0); if1.a0 = {1'b0, idx[2]};
      if1.req1 = (left[3] > 0); if1.a1 = {1'b1, idx[3]};
   endtask

   // One clock: detect accepts before the edge, update the requesters after it.
   task automatic cycle();
      logic acc [4];
      @(negedge clk);
      acc[0] = if4.req0 && if4.gnt0;
      acc[1] = if4.req1 && if4.gnt1;
      acc[2] = if1.req0 && if1.gnt0;
      acc[3] = if1.req1 && if1.gnt1;
      if (alt_en && (acc[2] || acc[3])) begin
         check("alt_sel", {31'd0, if1.selection}, {31'd0, alt_sel});
         alt_sel = !alt_sel;
      end
      @(posedge clk);
      #1;
      for (int p = 0; p < 4; p++) begin
         if (acc[p]) begin
            left[p]--;
            idx[p]++;
         end
      end
      drive();
   endtask

   task automatic clear_requesters();
      for (int p = 0; p < 4; p++) begin
         left[p] = 0;
         idx[p]  = '0;
      end
      drive();
   endtask

   task automatic do_reset();
      reset = 1'b1;
      clear_requesters();
      @(posedge clk);
      #1;
      q4.delete();
      q1.delete();
      reset = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int budget);
      int n = 0;
      while (!(left[0] == 0 && left[1] == 0 && left[2] == 0 && left[3] == 0 &&
               q4.size() == 0 && q1.size() == 0 &&
               !if4.y_valid && !if1.y_valid && !if4.busy && !if1.busy)) begin
         if (n == budget) begin
            check({name, "_timeout"}, 32'(n), 32'(budget + 1));
            return;
         end
         cycle();
         n++;
      end
   endtask

   // Monitors: pop and compare whenever a word leaves an instance.
   always @(negedge clk) begin
      if (!reset && if4.y_valid && if4.y_ready) begin
         if (q4.size() == 0) check("y4_unexpected", {27'd0, if4.y}, 32'hFFFF_FFFF);
         else                check("y4", {27'd0, if4.y}, {27'd0, q4.pop_front()});
      end
   end

   always @(negedge clk) begin
      if (!reset && if1.y_valid && if1.y_ready) begin
         if (q1.size() == 0) check("y1_unexpected", {27'd0, if1.y}, 32'hFFFF_FFFF);
         else                check("y1", {27'd0, if1.y}, {27'd0, q1.pop_front()});
      end
   end

   initial begin
      reset       = 1'b1;
      if4.y_ready = 1'b1;
      if1.y_ready = 1'b1;
      clear_requesters();
      #1;
      check("rst_y",         {27'd0, if4.y},    32'd0);
      check("rst_y_valid",   {31'd0, if4.y_valid}, 32'd0);
      check("rst_gnt0",      {31'd0, if4.gnt0}, 32'd0);
      check("rst_gnt1",      {31'd0, if4.gnt1}, 32'd0);
      check("rst_busy",      {31'd0, if4.busy}, 32'd0);
      check("rst_selection", {31'd0, if4.selection}, 32'd0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      @(posedge clk);
      #1;

      // Single requester: words 0A..0E back to back.
      left[0] = 5;
      idx[0]  = 4'hA;
      for (int k = 0; k < 5; k++) q4.push_back(5'h0A + 5'(k));
      drive();
      #1;
      check("single_no_gnt_in_idle", {31'd0, if4.gnt0}, 32'd0);
      cycle();
      check("single_gnt0_t1",   {31'd0, if4.gnt0}, 32'd1);
      check("single_no_y_t1",   {31'd0, if4.y_valid}, 32'd0);
      for (int k = 0; k < 5; k++) begin
         cycle();
         check("single_y_valid_nogap", {31'd0, if4.y_valid}, 32'd1);
         check("single_selection",     {31'd0, if4.selection}, 32'd0);
      end
      wait_idle("single", 20);

      // Backpressure: stall after the first word, then resume.
      left[0] = 3;
      idx[0]  = 4'h1;
      q4.push_back(5'h01);
      q4.push_back(5'h02);
      q4.push_back(5'h03);
      drive();
      cycle();
      cycle();
      if4.y_ready = 1'b0;
      #1;
      check("bp_gnt0_low", {31'd0, if4.gnt0}, 32'd0);
      for (int k = 0; k < 3; k++) begin
         cycle();
         check("bp_y_hold",       {27'd0, if4.y}, 32'h01);
         check("bp_y_valid_hold", {31'd0, if4.y_valid}, 32'd1);
         check("bp_gnt0_hold",    {31'd0, if4.gnt0}, 32'd0);
      end
      if4.y_ready = 1'b1;
      wait_idle("backpressure", 20);

      // Owner drop while the peer waits: OWN0 -> OWN1 without an IDLE cycle.
      do_reset();
      left[0] = 2;
      left[1] = 2;
      q4.push_back(5'h00);
      q4.push_back(5'h01);
      q4.push_back(5'h10);
      q4.push_back(5'h11);
      drive();
      cycle();
      check("drop_first_gnt0", {31'd0, if4.gnt0}, 32'd1);
      cycle();
      cycle();
      cycle();
      check("drop_selection", {31'd0, if4.selection}, 32'd1);
      check("drop_busy",      {31'd0, if4.busy}, 32'd1);
      check("drop_gnt1",      {31'd0, if4.gnt1}, 32'd1);
      check("drop_gnt0",      {31'd0, if4.gnt0}, 32'd0);
      wait_idle("drop", 20);

      // Tie from reset: bursts of 4 on dut4, strict alternation on dut1.
      do_reset();
      left[0] = 8;
      left[1] = 8;
      left[2] = 4;
      left[3] = 4;
      for (int k = 0; k < 4; k++) q4.push_back(5'h00 + 5'(k));
      for (int k = 0; k < 4; k++) q4.push_back(5'h10 + 5'(k));
      for (int k = 4; k < 8; k++) q4.push_back(5'h00 + 5'(k));
      for (int k = 4; k < 8; k++) q4.push_back(5'h10 + 5'(k));
      for (int k = 0; k < 4; k++) begin
         q1.push_back(5'h00 + 5'(k));
         q1.push_back(5'h10 + 5'(k));
      end
      alt_en  = 1'b1;
      alt_sel = 1'b0;
      drive();
      cycle();
      check("tie_gnt0_first",  {31'd0, if4.gnt0}, 32'd1);
      check("tie_gnt1_wait",   {31'd0, if4.gnt1}, 32'd0);
      check("tie1_gnt0_first", {31'd0, if1.gnt0}, 32'd1);
      for (int k = 0; k < 16; k++) begin
         cycle();
         check("tie_y_valid_nogap", {31'd0, if4.y_valid}, 32'd1);
      end
      wait_idle("tie", 40);
      alt_en = 1'b0;

      // Reset mid-burst with a word sitting in the output stage.
      left[0] = 4;
      idx[0]  = 4'h0;
      for (int k = 0; k < 4; k++) q4.push_back(5'h00 + 5'(k));
      drive();
      cycle();
      cycle();
      check("mid_pre_y_valid", {31'd0, if4.y_valid}, 32'd1);
      reset = 1'b1;
      #1;
      check("mid_y",         {27'd0, if4.y}, 32'd0);
      check("mid_y_valid",   {31'd0, if4.y_valid}, 32'd0);
      check("mid_gnt0",      {31'd0, if4.gnt0}, 32'd0);
      check("mid_gnt1",      {31'd0, if4.gnt1}, 32'd0);
      check("mid_busy",      {31'd0, if4.busy}, 32'd0);
      check("mid_selection", {31'd0, if4.selection}, 32'd0);
      clear_requesters();
      @(posedge clk);
      #1;
      q4.delete();
      q1.delete();
      reset = 1'b0;
      for (int k = 0; k < 3; k++) cycle();

      check("q4_drained", 32'(q4.size()), 32'd0);
      check("q1_drained", 32'(q1.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
